// File: rtl/popcount_pkg.sv
// Shared types and widths for the popcount frame controller.
package popcount_pkg;

    localparam int BYTE_W = 8;
    localparam int POP_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bit_counter.sv
// Combinational population count of one byte.
module bit_counter
    import popcount_pkg::*;
(
    input  logic [BYTE_W-1:0] data,
    output logic [POP_W-1:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            count = count + POP_W'(data[i]);
        end
    end

endmodule

// File: rtl/popcount_frame_ctrl.sv
// Accumulates the number of set bits over a frame of up to MAX_LEN bytes.
// Optional per-frame maximum byte count enabled by POPCOUNT_FRAME_STATS_EN.
module popcount_frame_ctrl
    import popcount_pkg::*;
#(
    parameter int MAX_LEN = 16,
    localparam int LEN_W  = $clog2(MAX_LEN + 1),
    localparam int CNT_W  = $clog2(MAX_LEN * 8 + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
`ifdef POPCOUNT_FRAME_STATS_EN
    output logic [POP_W-1:0]  max_ones,
`endif
    output logic [CNT_W-1:0]  total
);

    state_t             state_q;
    state_t             state_d;
    logic [LEN_W-1:0]   remaining_q;
    logic [LEN_W-1:0]   len_clamped;
    logic [CNT_W-1:0]   total_q;
    logic [POP_W-1:0]   byte_pop;
    logic               accept;

    bit_counter u_bit_counter (
        .data  (in_byte),
        .count (byte_pop)
    );

    // Oversized requests are silently truncated to the frame limit.
    assign len_clamped = (frame_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : frame_len;

    assign in_ready = (state_q == ST_ACCUM) && !abort;
    assign accept   = in_ready && in_valid;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign total    = total_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (frame_len == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (accept && (remaining_q == LEN_W'(1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining_q <= '0;
            total_q     <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            remaining_q <= len_clamped;
            total_q     <= '0;
        end else if ((state_q == ST_ACCUM) && abort) begin
            remaining_q <= '0;
            total_q     <= '0;
        end else if (accept) begin
            remaining_q <= remaining_q - LEN_W'(1);
            total_q     <= total_q + CNT_W'(byte_pop);
        end
    end

`ifdef POPCOUNT_FRAME_STATS_EN
    logic [POP_W-1:0] max_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            max_q <= '0;
        end else if ((state_q == ST_ACCUM) && abort) begin
            max_q <= '0;
        end else if (accept && (byte_pop > max_q)) begin
            max_q <= byte_pop;
        end
    end

    assign max_ones = max_q;
`endif

endmodule

// File: tb/tb_popcount_frame_ctrl.sv
// Directed self-checking bench for popcount_frame_ctrl (default MAX_LEN=16).
// max_ones checks are compiled in only with POPCOUNT_FRAME_STATS_EN.
module tb_popcount_frame_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] frame_len;
    logic       abort;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [7:0] total;
`ifdef POPCOUNT_FRAME_STATS_EN
    logic [3:0] max_ones;
`endif

    int checkCount = 0;
    int failCount  = 0;

    popcount_frame_ctrl #(.MAX_LEN(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .frame_len (frame_len),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
`ifdef POPCOUNT_FRAME_STATS_EN
        .max_ones  (max_ones),
`endif
        .total     (total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [4:0] len, input logic ab,
                                 input logic v, input logic [7:0] b);
        start     = s;
        frame_len = len;
        abort     = ab;
        in_valid  = v;
        in_byte   = b;
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkMax(input string tag, input logic [3:0] expected);
`ifdef POPCOUNT_FRAME_STATS_EN
        checkOutput(tag, 32'(max_ones), 32'(expected));
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 8'h00);
        #1;
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_total", 32'(total), 0);
        checkOutput("rst_ready", 32'(in_ready), 0);
        checkMax("rst_max", 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame; abort while IDLE must not block the start.
        applyStimulus(1, 5'd3, 1, 0, 8'h00);
        step();
        checkOutput("basic_busy", 32'(busy), 1);
        applyStimulus(0, 0, 0, 1, 8'h00);
        #1;
        checkOutput("basic_ready", 32'(in_ready), 1);
        step();
        applyStimulus(0, 0, 0, 1, 8'h01);
        step();
        checkOutput("basic_nodone", 32'(done), 0);
        checkOutput("basic_total2", 32'(total), 1);
        applyStimulus(0, 0, 0, 1, 8'h03);
        step();
        applyStimulus(0, 0, 0, 0, 8'h00);
        checkOutput("basic_done", 32'(done), 1);
        checkOutput("basic_total", 32'(total), 3);
        checkMax("basic_max", 2);
        step();
        checkOutput("basic_done_pulse", 32'(done), 0);
        checkOutput("basic_idle", 32'(busy), 0);
        checkOutput("basic_hold", 32'(total), 3);

        // Zero-length frame.
        applyStimulus(1, 5'd0, 0, 0, 8'h00);
        #1;
        checkOutput("zero_ready0", 32'(in_ready), 0);
        step();
        applyStimulus(0, 0, 0, 1, 8'hFF);
        checkOutput("zero_done", 32'(done), 1);
        checkOutput("zero_total", 32'(total), 0);
        checkOutput("zero_ready1", 32'(in_ready), 0);
        checkMax("zero_max", 0);
        step();
        applyStimulus(0, 0, 0, 0, 8'h00);
        checkOutput("zero_after", 32'(done), 0);
        checkOutput("zero_total_hold", 32'(total), 0);

        // Backpressure with idle gaps; stray start must be ignored.
        applyStimulus(1, 5'd2, 0, 0, 8'h00);
        step();
        applyStimulus(0, 0, 0, 1, 8'hFF);
        step();
        checkOutput("bp_total1", 32'(total), 8);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 5'd0, 0, 0, 8'hFF);
            step();
            checkOutput("bp_busy", 32'(busy), 1);
            checkOutput("bp_nodone", 32'(done), 0);
            checkOutput("bp_total_stall", 32'(total), 8);
        end
        applyStimulus(0, 0, 0, 1, 8'hFF);
        step();
        applyStimulus(0, 0, 0, 0, 8'h00);
        checkOutput("bp_done", 32'(done), 1);
        checkOutput("bp_busy_done", 32'(busy), 1);
        checkOutput("bp_total", 32'(total), 16);
        checkMax("bp_max", 8);
        step();

        // Abort wins over a simultaneous valid byte.
        applyStimulus(1, 5'd4, 0, 0, 8'h00);
        step();
        applyStimulus(0, 0, 0, 1, 8'h0F);
        step();
        checkOutput("abort_total1", 32'(total), 4);
        applyStimulus(0, 0, 1, 1, 8'hFF);
        #1;
        checkOutput("abort_ready", 32'(in_ready), 0);
        step();
        applyStimulus(0, 0, 0, 0, 8'h00);
        checkOutput("abort_idle", 32'(busy), 0);
        checkOutput("abort_nodone", 32'(done), 0);
        checkOutput("abort_total", 32'(total), 0);
        checkMax("abort_max", 0);
        step();
        checkOutput("abort_nodone2", 32'(done), 0);

        // Length clamp: 20 requested, 16 accepted, 17th ignored.
        applyStimulus(1, 5'd20, 0, 0, 8'h00);
        step();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 0, 1, 8'hFF);
            step();
            if (i < 15) checkOutput("clamp_nodone", 32'(done), 0);
        end
        checkOutput("clamp_done", 32'(done), 1);
        checkOutput("clamp_total", 32'(total), 128);
        checkOutput("clamp_ready", 32'(in_ready), 0);
        checkMax("clamp_max", 8);
        step();
        applyStimulus(0, 0, 0, 0, 8'h00);
        checkOutput("clamp_idle", 32'(busy), 0);
        checkOutput("clamp_hold", 32'(total), 128);

        // Asynchronous reset mid-frame, then a fresh one-byte frame.
        applyStimulus(1, 5'd5, 0, 0, 8'h00);
        step();
        applyStimulus(0, 0, 0, 1, 8'hFF);
        step();
        applyStimulus(0, 0, 0, 1, 8'h01);
        step();
        checkOutput("rst_mid_total", 32'(total), 9);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(busy), 0);
        checkOutput("arst_total", 32'(total), 0);
        checkOutput("arst_ready", 32'(in_ready), 0);
        checkOutput("arst_done", 32'(done), 0);
        checkMax("arst_max", 0);
        applyStimulus(0, 0, 0, 0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 5'd1, 0, 0, 8'h00);
        step();
        checkOutput("post_rst_busy", 32'(busy), 1);
        applyStimulus(0, 0, 0, 1, 8'h80);
        step();
        applyStimulus(0, 0, 0, 0, 8'h00);
        checkOutput("post_rst_done", 32'(done), 1);
        checkOutput("post_rst_total", 32'(total), 1);
        checkMax("post_rst_max", 1);
        step();
        checkOutput("post_rst_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
